// File: rtl/guess_tracker_pkg.sv
// Shared constants and state encoding for the guess tracker and the letter-draw datapath.
package guess_tracker_pkg;

    localparam int WORD_LEN_DEFAULT  = 10;
    localparam int MAX_WRONG_DEFAULT = 6;

    localparam logic [7:0] LOWER_A  = 8'h61;
    localparam logic [7:0] LOWER_Z  = 8'h7A;
    localparam logic [7:0] UPPER_A  = 8'h41;
    localparam logic [7:0] UPPER_Z  = 8'h5A;
    localparam logic [7:0] CASE_BIT = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_CHECK,
        ST_REPORT,
        ST_WON,
        ST_LOST
    } state_t;

    // Position of a folded lowercase letter in the 26-bit guessed set ('a' -> 0).
    function automatic logic [4:0] letterIndex(input logic [7:0] folded);
        return folded[4:0] - 5'd1;
    endfunction

endpackage

// File: rtl/guess_tracker_ascii_fold.sv
// Case fold: uppercase ASCII letters map to lowercase, everything else passes through.
module ascii_fold
    import guess_tracker_pkg::*;
(
    input  logic [7:0] char_i,
    output logic [7:0] folded_o,
    output logic       is_letter_o
);

    logic isUpper;
    logic isLower;

    assign isUpper     = (char_i >= UPPER_A) && (char_i <= UPPER_Z);
    assign isLower     = (char_i >= LOWER_A) && (char_i <= LOWER_Z);
    assign folded_o    = isUpper ? (char_i | CASE_BIT) : char_i;
    assign is_letter_o = isUpper || isLower;

endmodule

// File: rtl/guess_tracker.sv
// Hangman game state: latches the word, scans it one slot per cycle per guess,
// and keeps the reveal mask, guessed-letter set, wrong count and win/lose flags.
module guess_tracker
    import guess_tracker_pkg::*;
#(
    parameter int WORD_LEN  = WORD_LEN_DEFAULT,
    parameter int MAX_WRONG = MAX_WRONG_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  word_load,
    input  logic [8*WORD_LEN-1:0] word_letters,
    input  logic [3:0]            word_len,
    input  logic                  guess_valid,
    input  logic [7:0]            guess_letter,
    output logic                  guess_ready,
    output logic                  result_valid,
    output logic                  result_hit,
    output logic                  result_dup,
    output logic                  result_bad,
    output logic [WORD_LEN-1:0]   reveal_mask,
    output logic [2:0]            wrong_count,
    output logic                  win,
    output logic                  lose
);

    state_t                state_q;
    logic [8*WORD_LEN-1:0] word_q;
    logic [3:0]            wordLen_q;
    logic [3:0]            idx_q;
    logic [7:0]            guess_q;
    logic [25:0]           guessed_q;
    logic                  hit_q;
    logic                  bad_q;
    logic                  dup_q;
    logic                  hold_q;
    logic [WORD_LEN-1:0]   mask_q;
    logic [2:0]            wrong_q;
    logic                  win_q;
    logic                  lose_q;
    logic                  resValid_q;
    logic                  resHit_q;
    logic                  resDup_q;
    logic                  resBad_q;

    logic [7:0]            guessFolded;
    logic                  guessIsLetter;
    logic [7:0]            slotRaw;
    logic [7:0]            slotFolded;
    logic                  slotIsLetter;
    logic [4:0]            guessIdx;
    logic                  alreadyGuessed;
    logic [3:0]            wordLen_d;
    logic [2:0]            wrong_d;
    logic [WORD_LEN-1:0]   usedMask;
    logic                  allRevealed;

    ascii_fold guessFold (
        .char_i      (guess_letter),
        .folded_o    (guessFolded),
        .is_letter_o (guessIsLetter)
    );

    ascii_fold slotFold (
        .char_i      (slotRaw),
        .folded_o    (slotFolded),
        .is_letter_o (slotIsLetter)
    );

    assign guessIdx       = letterIndex(guessFolded);
    assign alreadyGuessed = guessed_q[guessIdx];
    assign allRevealed    = &(mask_q | ~usedMask);

    always_comb begin
        slotRaw = word_q[7:0];
        for (int i = 0; i < WORD_LEN; i++) begin
            if (4'(i) == idx_q) slotRaw = word_q[8*i +: 8];
        end
    end

    always_comb begin
        usedMask = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            usedMask[i] = (4'(i) < wordLen_q);
        end
    end

    always_comb begin
        wordLen_d = word_len;
        if (word_len == 4'd0) wordLen_d = 4'd1;
        else if (word_len > 4'(WORD_LEN)) wordLen_d = 4'(WORD_LEN);
    end

    always_comb begin
        wrong_d = wrong_q;
        if (!hit_q && !bad_q && !dup_q && (wrong_q != 3'(MAX_WRONG))) wrong_d = wrong_q + 3'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            wordLen_q  <= '0;
            idx_q      <= '0;
            guess_q    <= '0;
            guessed_q  <= '0;
            hit_q      <= 1'b0;
            bad_q      <= 1'b0;
            dup_q      <= 1'b0;
            hold_q     <= 1'b0;
            mask_q     <= '0;
            wrong_q    <= '0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            resValid_q <= 1'b0;
            resHit_q   <= 1'b0;
            resDup_q   <= 1'b0;
            resBad_q   <= 1'b0;
        end else begin
            resValid_q <= 1'b0;
            if (word_load) begin
                state_q   <= ST_PLAY;
                word_q    <= word_letters;
                wordLen_q <= wordLen_d;
                idx_q     <= '0;
                guessed_q <= '0;
                hit_q     <= 1'b0;
                bad_q     <= 1'b0;
                dup_q     <= 1'b0;
                hold_q    <= 1'b0;
                mask_q    <= '0;
                wrong_q   <= '0;
                win_q     <= 1'b0;
                lose_q    <= 1'b0;
                resHit_q  <= 1'b0;
                resDup_q  <= 1'b0;
                resBad_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_PLAY: begin
                        if (guess_valid) begin
                            guess_q <= guessFolded;
                            hit_q   <= 1'b0;
                            bad_q   <= !guessIsLetter;
                            dup_q   <= guessIsLetter && alreadyGuessed;
                            if (!guessIsLetter || alreadyGuessed) begin
                                hold_q  <= 1'b1;
                                state_q <= ST_REPORT;
                            end else begin
                                guessed_q[guessIdx] <= 1'b1;
                                idx_q               <= '0;
                                state_q             <= ST_CHECK;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (slotIsLetter && (slotFolded == guess_q)) begin
                            mask_q[idx_q] <= 1'b1;
                            hit_q         <= 1'b1;
                        end
                        if (idx_q == wordLen_q - 4'd1) state_q <= ST_REPORT;
                        else idx_q <= idx_q + 4'd1;
                    end
                    // Bad/dup guesses skip the scan but wait one extra cycle here for a fixed 2-cycle result.
                    ST_REPORT: begin
                        if (hold_q) begin
                            hold_q <= 1'b0;
                        end else begin
                            resValid_q <= 1'b1;
                            resHit_q   <= hit_q;
                            resDup_q   <= dup_q;
                            resBad_q   <= bad_q;
                            wrong_q    <= wrong_d;
                            if (allRevealed) begin
                                win_q   <= 1'b1;
                                state_q <= ST_WON;
                            end else if (wrong_d == 3'(MAX_WRONG)) begin
                                lose_q  <= 1'b1;
                                state_q <= ST_LOST;
                            end else begin
                                state_q <= ST_PLAY;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign guess_ready  = (state_q == ST_PLAY);
    assign result_valid = resValid_q;
    assign result_hit   = resHit_q;
    assign result_dup   = resDup_q;
    assign result_bad   = resBad_q;
    assign reveal_mask  = mask_q;
    assign wrong_count  = wrong_q;
    assign win          = win_q;
    assign lose         = lose_q;

endmodule

// File: tb/tb_guess_tracker.sv
// Directed self-checking bench for guess_tracker with hand-computed expectations.
module tb_guess_tracker;

    logic        clock = 1'b0;
    logic        reset;
    logic        word_load;
    logic [79:0] word_letters;
    logic [3:0]  word_len;
    logic        guess_valid;
    logic [7:0]  guess_letter;
    logic        guess_ready;
    logic        result_valid;
    logic        result_hit;
    logic        result_dup;
    logic        result_bad;
    logic [9:0]  reveal_mask;
    logic [2:0]  wrong_count;
    logic        win;
    logic        lose;

    int checks   = 0;
    int failures = 0;

    guess_tracker dut (
        .clock        (clock),
        .reset        (reset),
        .word_load    (word_load),
        .word_letters (word_letters),
        .word_len     (word_len),
        .guess_valid  (guess_valid),
        .guess_letter (guess_letter),
        .guess_ready  (guess_ready),
        .result_valid (result_valid),
        .result_hit   (result_hit),
        .result_dup   (result_dup),
        .result_bad   (result_bad),
        .reveal_mask  (reveal_mask),
        .wrong_count  (wrong_count),
        .win          (win),
        .lose         (lose)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic loadWord(input string w, input logic [3:0] len);
        word_letters = '0;
        for (int i = 0; i < w.len(); i++) word_letters[8*i +: 8] = w[i];
        word_len  = len;
        word_load = 1'b1;
        @(posedge clock); #1;
        word_load = 1'b0;
    endtask

    // Offer one guess for one cycle, then count cycles until result_valid (bounded).
    task automatic applyStimulus(input logic [7:0] g, output int lat, output logic readyAfter);
        guess_valid  = 1'b1;
        guess_letter = g;
        @(posedge clock); #1;
        guess_valid = 1'b0;
        readyAfter  = guess_ready;
        lat = 0;
        while (!result_valid && lat < 30) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic pokeIgnored(input logic [7:0] g, input int cycles, output int pulses);
        pulses       = 0;
        guess_valid  = 1'b1;
        guess_letter = g;
        repeat (cycles) begin
            @(posedge clock); #1;
            if (result_valid) pulses++;
        end
        guess_valid = 1'b0;
    endtask

    initial begin
        int          lat;
        int          pulses;
        int          wrongExp;
        logic        rdy;
        logic [7:0]  g;
        logic        isDup;
        string       seqStr;

        reset        = 1'b1;
        word_load    = 1'b0;
        word_letters = '0;
        word_len     = '0;
        guess_valid  = 1'b0;
        guess_letter = '0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_ready", guess_ready, 0);
        checkOutput("rst_valid", result_valid, 0);
        checkOutput("rst_mask", reveal_mask, 0);
        checkOutput("rst_wrong", wrong_count, 0);
        checkOutput("rst_winlose", {win, lose}, 0);
        reset = 1'b0;
        pokeIgnored("a", 4, pulses);
        checkOutput("idle_ignore", pulses, 0);

        // hangman: first hit reveals both 'a' slots
        loadWord("hangman", 4'd7);
        checkOutput("hm_ready", guess_ready, 1);
        applyStimulus("a", lat, rdy);
        checkOutput("hm_ready_drop", rdy, 0);
        checkOutput("hm_lat", lat, 8);
        checkOutput("hm_hit", result_hit, 1);
        checkOutput("hm_mask", reveal_mask, 10'b0000100010);
        checkOutput("hm_wrong", wrong_count, 0);

        seqStr   = "zzqzxzvzwzy";
        wrongExp = 0;
        for (int i = 0; i < seqStr.len(); i++) begin
            g     = seqStr[i];
            isDup = (i > 0) && (g == 8'h7A);
            applyStimulus(g, lat, rdy);
            if (!isDup) wrongExp++;
            checkOutput("seq_lat", lat, isDup ? 2 : 8);
            checkOutput("seq_dup", result_dup, isDup);
            checkOutput("seq_hit", result_hit, 0);
            checkOutput("seq_wrong", wrong_count, wrongExp);
        end
        checkOutput("lose_flag", lose, 1);
        checkOutput("lose_win", win, 0);
        checkOutput("lose_ready", guess_ready, 0);
        checkOutput("lose_mask", reveal_mask, 10'b0000100010);

        // ab: case-folded guess, then win
        loadWord("ab", 4'd2);
        checkOutput("ab_clear", {lose, win, wrong_count, reveal_mask}, 0);
        checkOutput("ab_ready", guess_ready, 1);
        applyStimulus("B", lat, rdy);
        checkOutput("ab_b_lat", lat, 3);
        checkOutput("ab_b_hit", result_hit, 1);
        checkOutput("ab_b_mask", reveal_mask, 10'b10);
        checkOutput("ab_b_win", win, 0);
        applyStimulus("a", lat, rdy);
        checkOutput("ab_a_lat", lat, 3);
        checkOutput("ab_win", win, 1);
        checkOutput("ab_mask", reveal_mask, 10'b11);
        checkOutput("ab_won_ready", guess_ready, 0);
        pokeIgnored("c", 5, pulses);
        checkOutput("won_ignore", pulses, 0);
        checkOutput("won_hold", win, 1);

        // CAT: uppercase word, bad guess leaves state untouched
        loadWord("CAT", 4'd3);
        applyStimulus("5", lat, rdy);
        checkOutput("bad_lat", lat, 2);
        checkOutput("bad_flag", result_bad, 1);
        checkOutput("bad_hit", result_hit, 0);
        checkOutput("bad_wrong", wrong_count, 0);
        checkOutput("bad_mask", reveal_mask, 0);
        applyStimulus("c", lat, rdy);
        checkOutput("cat_c_lat", lat, 4);
        checkOutput("cat_c_flags", {result_hit, result_dup, result_bad}, 3'b100);
        checkOutput("cat_c_mask", reveal_mask, 10'b001);
        applyStimulus("T", lat, rdy);
        checkOutput("cat_t_mask", reveal_mask, 10'b101);

        // word_len 0 behaves as 1
        loadWord("x", 4'd0);
        applyStimulus("X", lat, rdy);
        checkOutput("len0_lat", lat, 2);
        checkOutput("len0_win", win, 1);
        checkOutput("len0_mask", reveal_mask, 10'b1);

        // word_len above 10 clamps to 10
        loadWord("abcdefghij", 4'd15);
        applyStimulus("j", lat, rdy);
        checkOutput("clamp_lat", lat, 11);
        checkOutput("clamp_mask", reveal_mask, 10'b1000000000);
        applyStimulus("z", lat, rdy);
        checkOutput("clamp_miss_wrong", wrong_count, 1);

        // word_load aborts a scan in progress
        guess_valid  = 1'b1;
        guess_letter = "b";
        @(posedge clock); #1;
        guess_valid = 1'b0;
        pulses = 0;
        repeat (3) begin
            @(posedge clock); #1;
            if (result_valid) pulses++;
        end
        loadWord("hangman", 4'd7);
        if (result_valid) pulses++;
        checkOutput("abort_ready", guess_ready, 1);
        checkOutput("abort_mask", reveal_mask, 0);
        checkOutput("abort_wrong", wrong_count, 0);
        repeat (12) begin
            @(posedge clock); #1;
            if (result_valid) pulses++;
        end
        checkOutput("abort_pulses", pulses, 0);

        // reset while in REPORT
        guess_valid  = 1'b1;
        guess_letter = "h";
        @(posedge clock); #1;
        guess_valid = 1'b0;
        repeat (7) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        checkOutput("rep_rst_valid", result_valid, 0);
        checkOutput("rep_rst_ready", guess_ready, 0);
        checkOutput("rep_rst_outs", {result_hit, result_dup, result_bad, reveal_mask, wrong_count, win, lose}, 0);
        reset = 1'b0;
        @(posedge clock); #1;
        checkOutput("rep_rst_idle", guess_ready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
